// File: rtl/shift_pkg.sv
// Shared types for the sequenced shift register: FSM states, fill/rotate modes, shift direction.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_SER = 2'b11
  } mode_e;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter: moves a WIDTH-bit word by k bits (0..STEP)
// and reports the last bit that left the word.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [AMT_W-1:0] k,
  input  logic             dir,
  input  mode_e            mode,
  input  logic             sin,
  output logic [WIDTH-1:0] word_nxt,
  output logic             bit_out
);

  localparam logic [AMT_W-1:0] WIDTH_C = AMT_W'(WIDTH);

  logic [AMT_W-1:0] k_inv;
  logic [WIDTH-1:0] shl, shr, wrap_l, wrap_r, lmask, rmask;

  // wrap_l/wrap_r are the bits that fall off each end, realigned to the opposite end
  always_comb begin
    k_inv  = WIDTH_C - k;
    shl    = word << k;
    shr    = word >> k;
    wrap_l = word >> k_inv;
    wrap_r = word << k_inv;
    lmask  = ~({WIDTH{1'b1}} << k);
    rmask  = ~({WIDTH{1'b1}} >> k);

    word_nxt = shl;
    bit_out  = 1'b0;
    if (dir == DIR_L) begin
      bit_out = wrap_l[0];
      case (mode)
        MODE_ROT: word_nxt = shl | wrap_l;
        MODE_SER: word_nxt = shl | (sin ? lmask : '0);
        default:  word_nxt = shl;
      endcase
    end else begin
      bit_out = wrap_r[WIDTH-1];
      case (mode)
        MODE_ROT: word_nxt = shr | wrap_r;
        MODE_ARI: word_nxt = shr | (word[WIDTH-1] ? rmask : '0);
        MODE_SER: word_nxt = shr | (sin ? rmask : '0);
        default:  word_nxt = shr;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_register.sv
// Parallel-load register with a multi-cycle shift sequence (STEP bits per clock) and start/busy/done handshake.
// Optional SHIFT_SEQ_PARITY_EN adds a registered even-parity output o_parity.
module shift_seq_register
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] din,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] dout,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
`ifdef SHIFT_SEQ_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  localparam logic [AMT_W-1:0] WIDTH_C = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_C  = AMT_W'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d, step_word;
  logic             sout_q, sout_d, step_bit;
  logic [AMT_W-1:0] rem_q, rem_d, k, n_req;
  logic             dir_q, dir_d;
  mode_e            mode_q, mode_d;

  shift_step_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .word     (dout_q),
    .k        (k),
    .dir      (dir_q),
    .mode     (mode_q),
    .sin      (i_sin),
    .word_nxt (step_word),
    .bit_out  (step_bit)
  );

  always_comb begin
    k     = (rem_q > STEP_C) ? STEP_C : rem_q;
    n_req = (i_amt > WIDTH_C) ? WIDTH_C : i_amt;

    state_d = state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (i_load) begin
          dout_d = din;
        end else if (i_start) begin
          dir_d   = i_dir;
          mode_d  = mode_e'(i_mode);
          rem_d   = n_req;
          state_d = (n_req == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // a load mid-sequence abandons the shift without a done pulse
        if (i_load) begin
          dout_d  = din;
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          dout_d = step_word;
          sout_d = step_bit;
          rem_d  = rem_q - k;
          if (rem_q == k) state_d = DONE;
        end
      end
      default: begin
        if (i_load) dout_d = din;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      rem_q   <= '0;
      dir_q   <= DIR_L;
      mode_q  <= MODE_LOG;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  logic parity_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_q <= 1'b0;
    else          parity_q <= ^dout_d;
  end
  assign o_parity = parity_q;
`endif

  assign dout   = dout_q;
  assign o_sout = sout_q;
  assign o_busy = (state_q == SHIFT);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq_register.sv
// Directed bench for shift_seq_register: one STEP=1 and one STEP=4 instance, hand-computed expectations.
module tb_shift_seq_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load, start, dir, sin;
  logic [15:0] din;
  logic [4:0]  amt;
  logic [1:0]  mode;
  logic [15:0] dout;
  logic        sout, busy, done;

  logic        load4, start4, dir4, sin4;
  logic [15:0] din4;
  logic [4:0]  amt4;
  logic [1:0]  mode4;
  logic [15:0] dout4;
  logic        sout4, busy4, done4;

`ifdef SHIFT_SEQ_PARITY_EN
  logic par1, par4;
`endif

  int total = 0;
  int bad   = 0;

  shift_seq_register #(.WIDTH(16), .STEP(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .din(din), .i_start(start),
    .i_amt(amt), .i_dir(dir), .i_mode(mode), .i_sin(sin),
    .dout(dout), .o_sout(sout), .o_busy(busy), .o_done(done)
`ifdef SHIFT_SEQ_PARITY_EN
    , .o_parity(par1)
`endif
  );

  shift_seq_register #(.WIDTH(16), .STEP(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load4), .din(din4), .i_start(start4),
    .i_amt(amt4), .i_dir(dir4), .i_mode(mode4), .i_sin(sin4),
    .dout(dout4), .o_sout(sout4), .o_busy(busy4), .o_done(done4)
`ifdef SHIFT_SEQ_PARITY_EN
    , .o_parity(par4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load1(input logic [15:0] d);
    load = 1'b1;
    din  = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // pulse start, then wait (bounded) for done; checks latency, busy cycles and single-cycle done
  task automatic run1(input logic [4:0] a, input logic d, input logic [1:0] m,
                      input int exp_lat, input string tag);
    int n_busy = 0;
    int lat    = 0;
    start = 1'b1; amt = a; dir = d; mode = m;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) n_busy++;
      if (done) lat = c;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, n_busy, exp_lat - 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int lat4, nb4, seen_done;
    rst_n = 1'b0;
    load = 0; start = 0; dir = 0; sin = 0; din = '0; amt = '0; mode = 2'b00;
    load4 = 0; start4 = 0; dir4 = 0; sin4 = 0; din4 = '0; amt4 = '0; mode4 = 2'b00;

    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_flags", {sout, busy, done}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // logical left 3
    load1(16'h8001);
    chk("load_8001", dout, 16'h8001);
    run1(5'd3, 1'b0, 2'b00, 4, "log_l3");
    chk("log_l3_dout", dout, 16'h0008);
    chk("log_l3_sout", sout, 1'b0);

    // rotate clamped to full width returns the word
    load1(16'h1234);
    run1(5'd20, 1'b0, 2'b10, 17, "rot_20");
    chk("rot_20_dout", dout, 16'h1234);
    chk("rot_20_sout", sout, 1'b0);
    run1(5'd4, 1'b0, 2'b10, 5, "rot_l4");
    chk("rot_l4_dout", dout, 16'h2341);
    chk("rot_l4_sout", sout, 1'b1);

    // serial fill right, then a zero-length request
    load1(16'h0000);
    sin = 1'b1;
    run1(5'd5, 1'b1, 2'b11, 6, "ser_r5");
    chk("ser_r5_dout", dout, 16'hF800);
    chk("ser_r5_sout", sout, 1'b0);
    run1(5'd0, 1'b1, 2'b11, 1, "amt0");
    chk("amt0_dout", dout, 16'hF800);
    sin = 1'b0;

    // load aborts on the second shift cycle
    load1(16'h8001);
    start = 1'b1; amt = 5'd8; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", busy, 1'b1);
    @(negedge clk);
    chk("abort_mid_dout", dout, 16'h0002);
    load = 1'b1; din = 16'h00FF;
    @(negedge clk);
    load = 1'b0;
    chk("abort_dout", dout, 16'h00FF);
    chk("abort_flags", {busy, done}, 2'b00);
    chk("abort_sout_hold", sout, 1'b1);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);

    // load beats start in the same cycle
    load = 1'b1; din = 16'h3C3C; start = 1'b1; amt = 5'd4;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("prio_dout", dout, 16'h3C3C);
    chk("prio_busy", busy, 1'b0);
    @(negedge clk);
    chk("prio_idle", {busy, done, dout}, {2'b00, 16'h3C3C});

    // async reset in the middle of a shift
    load1(16'h0F0F);
    start = 1'b1; amt = 5'd10; dir = 1'b1; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 16'h0000);
    chk("async_rst_flags", {sout, busy, done}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    load1(16'hA5C3);
    chk("post_rst_load", dout, 16'hA5C3);
    chk("post_rst_idle", {busy, done}, 2'b00);

    // STEP=4: arithmetic right 6 (4 then 2)
    load4 = 1'b1; din4 = 16'h8F00;
    @(negedge clk);
    load4 = 1'b0;
    chk("s4_load", dout4, 16'h8F00);
    start4 = 1'b1; amt4 = 5'd6; dir4 = 1'b1; mode4 = 2'b01;
    lat4 = 0; nb4 = 0;
    for (int c = 1; c <= 20 && lat4 == 0; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (busy4) nb4++;
      if (done4) lat4 = c;
    end
    chk("s4_ari_lat", lat4, 3);
    chk("s4_ari_busy", nb4, 2);
    chk("s4_ari_dout", dout4, 16'hFE3C);
    chk("s4_ari_sout", sout4, 1'b0);

    // STEP=4: logical left full width flushes the word
    load4 = 1'b1; din4 = 16'hFFFF;
    @(negedge clk);
    load4 = 1'b0;
    start4 = 1'b1; amt4 = 5'd16; dir4 = 1'b0; mode4 = 2'b00;
    lat4 = 0;
    for (int c = 1; c <= 20 && lat4 == 0; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) lat4 = c;
    end
    chk("s4_flush_lat", lat4, 5);
    chk("s4_flush_dout", dout4, 16'h0000);
    chk("s4_flush_sout", sout4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
